memref_rr_arbiter: RTL and testbench
====================================

MEMREF_RR_ARBITER -- requirements
Module: memref_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, memory data width in bits.
REQ-002 SHALL have parameter SIZE, default 8, memory depth in words; address width AW = $clog2(SIZE).
REQ-003 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-004 SHALL have parameter LOCK_MAX, default 8, maximum consecutive locked grants to one requester.
REQ-005 SHALL have one clock and asynchronous active-high reset: clk input 1 (rising edge), rst input 1.
REQ-006 req  input  NREQ  per-requester access request.
REQ-007 we  input  NREQ  per-requester write flag (1 write, 0 read), valid with req.
REQ-008 lock  input  NREQ  per-requester burst-lock hint; always present, used only per REQ-027/028.
REQ-009 addr  input  NREQ*AW  flattened addresses, requester i at [i*AW +: AW].
REQ-010 wdata  input  NREQ*WIDTH  flattened write data, requester i at [i*WIDTH +: WIDTH].
REQ-011 grant  output  NREQ  one-hot combinational grant; request i accepted in the cycle grant[i]=1.
REQ-012 rvalid  output  NREQ  per-requester read-data-valid.
REQ-013 rdata  output  WIDTH  read data shared by all requesters, qualified by rvalid.
REQ-014 mem_rd_en / mem_wr_en  output  1 each  memory port read / write strobes.
REQ-015 mem_addr  output  AW; mem_din  output  WIDTH  memory address and write data.
REQ-016 mem_dout  input  WIDTH; mem_dout_valid  input  1  memory read response, one cycle after mem_rd_en.
REQ-017 err  output  1  sticky protocol error flag.

Function
REQ-018 grant SHALL be one-hot when req!=0 and all-zero when req==0, within the same cycle.
REQ-019 Round-robin: winner SHALL be the first set bit of req scanning from ptr upward with wrap NREQ-1 -> 0.
REQ-020 On each grant to index g, ptr SHALL update to (g+1) mod NREQ at the next rising edge; ptr SHALL hold when no grant.
REQ-021 mem_rd_en SHALL equal |grant & ~we[g]; mem_wr_en SHALL equal |grant & we[g]; never both 1.
REQ-022 mem_addr / mem_din SHALL be combinationally muxed from winner g; don't-care (drive 0) when no grant.
REQ-023 On a read grant, owner register SHALL capture g; next cycle rvalid[owner]=mem_dout_valid, other rvalid bits 0.
REQ-024 rdata SHALL equal mem_dout combinationally; read latency = 1 cycle from grant to rvalid.
REQ-025 Back-to-back reads by different requesters SHALL each return to the correct owner, one per cycle.
REQ-026 mem_dout_valid=1 in a cycle with no read issued on the previous cycle SHALL set err; err clears only on rst.

Configuration
REQ-027 With MEMREF_ARB_LOCK_EN defined: if last winner g has req[g]&lock[g], g SHALL win again and ptr SHALL hold, for at most LOCK_MAX consecutive grants; the next cycle SHALL arbitrate by REQ-019 excluding g if others request.
REQ-028 Without MEMREF_ARB_LOCK_EN: lock SHALL be ignored, no lock counter SHALL be synthesized, arbitration SHALL be pure REQ-019.

Reset
REQ-029 rst=1 SHALL asynchronously set ptr=0, owner=0, read-pending=0, lock counter=0, err=0, rvalid=0.
REQ-030 While rst=1, grant, mem_rd_en and mem_wr_en SHALL be 0 regardless of req.
REQ-031 A read outstanding when rst asserts SHALL be dropped: no rvalid after reset release; err SHALL NOT set on that stale mem_dout_valid.

Verification
REQ-032 Reset then req=4'b1111 held, all reads: grant sequence 0001,0010,0100,1000,0001; rvalid follows one cycle behind with same bit.
REQ-033 req=4'b0101, we=4'b0001, addr0=3, wdata0=0xDEAD, addr2=3: cycle1 write by 0, cycle2 read by 2, rvalid[2]=1 with rdata=0xDEAD.
REQ-034 Only req[3] asserted after ptr=1: grant=1000 immediately, ptr becomes 0 (wrap).
REQ-035 MEMREF_ARB_LOCK_EN, LOCK_MAX=8, req=4'b0011, lock=4'b0001: requester 0 granted 8 consecutive cycles, then requester 1 granted; without macro, grants alternate 0,1,0,1.
REQ-036 Force mem_dout_valid=1 with no prior read: err=1 next cycle and stays 1 until rst; assert rst mid-read: no rvalid, err stays 0.

Source files
------------

// File: rtl/memref_rr_arbiter.sv
// Round-robin arbiter giving NREQ requesters shared access to a single-port memory with 1-cycle read latency.
// Optional burst lock is enabled by defining MEMREF_ARB_LOCK_EN.
module memref_rr_arbiter #(
   parameter int WIDTH    = 32,
   parameter int SIZE     = 8,
   parameter int NREQ     = 4,
   parameter int LOCK_MAX = 8,
   localparam int AW      = $clog2(SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      we,
   input  logic [NREQ-1:0]      lock,
   input  logic [NREQ*AW-1:0]   addr,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      rvalid,
   output logic [WIDTH-1:0]     rdata,
   output logic                 mem_rd_en,
   output logic                 mem_wr_en,
   output logic [AW-1:0]        mem_addr,
   output logic [WIDTH-1:0]     mem_din,
   input  logic [WIDTH-1:0]     mem_dout,
   input  logic                 mem_dout_valid,
   output logic                 err
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr;
   logic [PW-1:0] owner;
   logic [PW-1:0] win;
   logic [PW-1:0] ptr_nxt;
   logic          win_any;
   logic          gnt_any;
   logic          locked;
   logic          rd_pend;
   logic          skip_stale;
   logic [PW:0]   idx;

`ifdef MEMREF_ARB_LOCK_EN
   localparam int CW = $clog2(LOCK_MAX + 1);
   logic [PW-1:0] last_g;
   logic          last_valid;
   logic [CW-1:0] lock_cnt;
`else
   logic          unused_lock;
   assign unused_lock = ^lock;
`endif

   // Scan from ptr upward; iterating high-to-low offsets lets the nearest requester overwrite.
   always_comb begin
      win     = '0;
      win_any = 1'b0;
      locked  = 1'b0;
      idx     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ))
            idx = idx - (PW+1)'(NREQ);
         if (req[idx[PW-1:0]]) begin
            win     = idx[PW-1:0];
            win_any = 1'b1;
         end
      end
`ifdef MEMREF_ARB_LOCK_EN
      if (last_valid && req[last_g] && lock[last_g] && (lock_cnt < CW'(LOCK_MAX))) begin
         win     = last_g;
         win_any = 1'b1;
         locked  = 1'b1;
      end
`endif
   end

   assign gnt_any   = win_any & ~rst;
   assign grant     = gnt_any ? (NREQ'(1) << win) : '0;
   assign mem_rd_en = gnt_any & ~we[win];
   assign mem_wr_en = gnt_any & we[win];
   assign mem_addr  = gnt_any ? addr[win*AW +: AW] : '0;
   assign mem_din   = gnt_any ? wdata[win*WIDTH +: WIDTH] : '0;
   assign ptr_nxt   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

   assign rvalid = (rd_pend && mem_dout_valid) ? (NREQ'(1) << owner) : '0;
   assign rdata  = mem_dout;

   // skip_stale masks the response of a read that was in flight when reset hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr        <= '0;
         owner      <= '0;
         rd_pend    <= 1'b0;
         err        <= 1'b0;
         skip_stale <= 1'b1;
      end else begin
         skip_stale <= 1'b0;
         rd_pend    <= mem_rd_en;
         if (mem_rd_en)
            owner <= win;
         if (gnt_any && !locked)
            ptr <= ptr_nxt;
         if (mem_dout_valid && !rd_pend && !skip_stale)
            err <= 1'b1;
      end
   end

`ifdef MEMREF_ARB_LOCK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_g     <= '0;
         last_valid <= 1'b0;
         lock_cnt   <= '0;
      end else begin
         last_valid <= gnt_any;
         if (gnt_any) begin
            last_g <= win;
            if (last_valid && (win == last_g))
               lock_cnt <= (lock_cnt == CW'(LOCK_MAX)) ? lock_cnt : lock_cnt + 1'b1;
            else
               lock_cnt <= CW'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_memref_rr_arbiter.sv
// Self-checking bench for memref_rr_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_memref_rr_arbiter;

   localparam int WIDTH = 32;
   localparam int NREQ  = 4;
   localparam int AW    = 3;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NREQ-1:0]         req = '0;
   logic [NREQ-1:0]         we = '0;
   logic [NREQ-1:0]         lock = '0;
   logic [NREQ*AW-1:0]      addr = '0;
   logic [NREQ*WIDTH-1:0]   wdata = '0;
   logic [NREQ-1:0]         grant;
   logic [NREQ-1:0]         rvalid;
   logic [WIDTH-1:0]        rdata;
   logic                    mem_rd_en;
   logic                    mem_wr_en;
   logic [AW-1:0]           mem_addr;
   logic [WIDTH-1:0]        mem_din;
   logic [WIDTH-1:0]        mem_dout = '0;
   logic                    mem_dout_valid;
   logic                    err;

   logic                    dv_r = 1'b0;
   logic                    force_dv = 1'b0;
   logic [WIDTH-1:0]        dev_mem [8];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   memref_rr_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
      .grant(grant), .rvalid(rvalid), .rdata(rdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_dout_valid(mem_dout_valid),
      .err(err)
   );

   // Memory device: one-cycle read response, not reset, so an in-flight read survives reset.
   always @(posedge clk) begin
      dv_r <= mem_rd_en;
      if (mem_wr_en) dev_mem[mem_addr] <= mem_din;
      if (mem_rd_en) mem_dout <= dev_mem[mem_addr];
   end
   assign mem_dout_valid = dv_r | force_dv;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; we = '0; lock = '0; force_dv = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      cyc();
      rst = 1'b1; req = 4'b1111; we = 4'b0000;
      #3;
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
      checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
      checks++; if (rvalid !== 4'b0000) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      we = 4'b1111;
      #1;
      checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en); end
      req = '0; we = '0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_rr_reads();
      logic [3:0] exp_g [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      req = 4'b1111; we = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         #3;
         checks++; if (grant !== exp_g[i]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant, exp_g[i]); end
         checks++; if (rvalid !== ((i == 0) ? 4'b0000 : exp_g[i-1])) begin failures++; $display("FAIL rr_rvalid[%0d] got=%b", i, rvalid); end
         cyc();
      end
      req = '0;
      #3;
      checks++; if (rvalid !== exp_g[4]) begin failures++; $display("FAIL rr_rvalid_last got=%b exp=%b", rvalid, exp_g[4]); end
      cyc();
   endtask

   task automatic test_write_read();
      do_reset();
      req = 4'b0101; we = 4'b0001;
      addr = '0; addr[0 +: AW] = 3'd3; addr[2*AW +: AW] = 3'd3;
      wdata = '0; wdata[0 +: WIDTH] = 32'h0000_DEAD;
      #3;
      checks++; if (grant !== 4'b0001 || mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0)
         begin failures++; $display("FAIL wr_cycle grant=%b wr=%b rd=%b exp 0001/1/0", grant, mem_wr_en, mem_rd_en); end
      checks++; if (mem_addr !== 3'd3 || mem_din !== 32'h0000_DEAD)
         begin failures++; $display("FAIL wr_bus addr=%0d din=%h exp 3/dead", mem_addr, mem_din); end
      cyc();
      #3;
      checks++; if (grant !== 4'b0100 || mem_rd_en !== 1'b1)
         begin failures++; $display("FAIL rd_cycle grant=%b rd=%b exp 0100/1", grant, mem_rd_en); end
      cyc();
      req = '0; we = '0;
      #3;
      checks++; if (rvalid !== 4'b0100 || rdata !== 32'h0000_DEAD)
         begin failures++; $display("FAIL rd_return rvalid=%b rdata=%h exp 0100/dead", rvalid, rdata); end
      cyc();
   endtask

   task automatic test_wrap();
      do_reset();
      req = 4'b0001; we = '0;
      cyc();
      req = 4'b1000;
      #3;
      checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL wrap_grant got=%b exp=1000", grant); end
      cyc();
      req = 4'b1111;
      #3;
      checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL wrap_ptr got=%b exp=0001", grant); end
      cyc();
      req = '0;
      cyc();
   endtask

   task automatic test_lock();
      logic [3:0] exp_g;
      do_reset();
      req = 4'b0011; lock = 4'b0001; we = '0;
      for (int i = 0; i < 10; i++) begin
`ifdef MEMREF_ARB_LOCK_EN
         exp_g = (i == 8) ? 4'b0010 : 4'b0001;
`else
         exp_g = (i % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
         #3;
         checks++; if (grant !== exp_g) begin failures++; $display("FAIL lock_grant[%0d] got=%b exp=%b", i, grant, exp_g); end
         cyc();
      end
      req = '0; lock = '0;
      cyc();
   endtask

   task automatic test_err();
      do_reset();
      cyc();
      #3;
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_idle got=%b exp=0", err); end
      cyc();
      force_dv = 1'b1;
      cyc();
      force_dv = 1'b0;
      #3;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
      repeat (3) cyc();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
      rst = 1'b1;
      #1;
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      cyc();
      req = 4'b0001; we = '0; addr = '0; addr[0 +: AW] = 3'd5;
      #3;
      checks++; if (mem_rd_en !== 1'b1) begin failures++; $display("FAIL midrd_issue got=%b exp=1", mem_rd_en); end
      cyc();
      rst = 1'b1; req = '0;
      #1;
      checks++; if (rvalid !== 4'b0000) begin failures++; $display("FAIL midrd_rvalid_rst got=%b exp=0000", rvalid); end
      rst = 1'b0;
      #1;
      checks++; if (rvalid !== 4'b0000) begin failures++; $display("FAIL midrd_rvalid_rel got=%b exp=0000 dv=%b", rvalid, mem_dout_valid); end
      cyc();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrd_err got=%b exp=0", err); end
      cyc();
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] model_mem [8];
      int m_ptr, best, bdist, d, po, a;
      logic pv;
      logic [WIDTH-1:0] pd;
      logic [3:0] exp_g;
      do_reset();
      // Preload through the DUT so both memories are defined.
      for (int i = 0; i < 8; i++) begin
         req = 4'b0001; we = 4'b0001;
         addr = '0; addr[0 +: AW] = AW'(i);
         wdata = '0; wdata[0 +: WIDTH] = $urandom;
         model_mem[i] = wdata[0 +: WIDTH];
         cyc();
      end
      req = '0; we = '0;
      cyc();
      m_ptr = 1; pv = 1'b0; po = 0; pd = '0;
      for (int n = 0; n < 300; n++) begin
         req = 4'($urandom_range(0, 15));
         we = 4'($urandom_range(0, 15));
         addr = NREQ*AW'($urandom);
         for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = $urandom;
         best = -1; bdist = NREQ;
         for (int i = 0; i < NREQ; i++) begin
            d = (i - m_ptr + NREQ) % NREQ;
            if (req[i] && d < bdist) begin best = i; bdist = d; end
         end
         exp_g = (best >= 0) ? 4'(1 << best) : 4'b0000;
         #3;
         checks++; if (grant !== exp_g) begin failures++; $display("FAIL rnd_grant[%0d] got=%b exp=%b", n, grant, exp_g); end
         checks++; if (mem_rd_en !== (best >= 0 && !we[best]) || mem_wr_en !== (best >= 0 && we[best]))
            begin failures++; $display("FAIL rnd_strobe[%0d] rd=%b wr=%b", n, mem_rd_en, mem_wr_en); end
         if (best >= 0) begin
            checks++; if (mem_addr !== addr[best*AW +: AW]) begin failures++; $display("FAIL rnd_addr[%0d] got=%0d exp=%0d", n, mem_addr, addr[best*AW +: AW]); end
            if (we[best]) begin
               checks++; if (mem_din !== wdata[best*WIDTH +: WIDTH]) begin failures++; $display("FAIL rnd_din[%0d] got=%h", n, mem_din); end
            end
         end
         checks++; if (rvalid !== (pv ? 4'(1 << po) : 4'b0000)) begin failures++; $display("FAIL rnd_rvalid[%0d] got=%b pv=%b po=%0d", n, rvalid, pv, po); end
         if (pv) begin
            checks++; if (rdata !== pd) begin failures++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", n, rdata, pd); end
         end
         checks++; if (err !== 1'b0) begin failures++; $display("FAIL rnd_err[%0d] got=%b exp=0", n, err); end
         pv = 1'b0;
         if (best >= 0) begin
            a = int'(addr[best*AW +: AW]);
            if (we[best]) model_mem[a] = wdata[best*WIDTH +: WIDTH];
            else begin pv = 1'b1; po = best; pd = model_mem[a]; end
            m_ptr = (best + 1) % NREQ;
         end
         cyc();
      end
      req = '0; we = '0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_rr_reads();
      test_write_read();
      test_wrap();
      test_lock();
      test_err();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
